// File: rtl/ps2_key_rx.sv
// ps2_key_rx -- PS/2 keyboard receiver producing scan-set-2 key events.
//
// Both PS/2 lines are synchronized every clock. The clock line is
// glitch-filtered on ce. A falling edge of the filtered clock samples the
// data line into an 11-bit frame receiver: start, 8 data LSB first, odd
// parity, stop. E0 and F0 prefixes are folded into the extended and
// pressed flags of the following code.
//
// Optional feature macro: PS2_PARITY_EN
//   defined     -> frames failing odd parity are dropped with an error pulse
//   not defined -> the parity bit is sampled and ignored
//
// Ports:
//   clock    in   system clock, all logic on its rising edge
//   reset    in   synchronous active-high reset
//   ce       in   one-cycle clock enable shared with the keyboard matrix
//   ps2Ck    in   PS/2 clock line (asynchronous, idles high)
//   ps2Dt    in   PS/2 data line (asynchronous, idles high)
//   strobe   out  one-clock pulse per key event
//   pressed  out  1 = make, 0 = break
//   extended out  1 = event was prefixed by E0
//   code     out  scan code with prefixes removed
//   error    out  one-clock pulse on framing, parity or timeout error
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 16384
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2Dt,
    output logic       strobe,
    output logic       pressed,
    output logic       extended,
    output logic [7:0] code,
    output logic       error
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } stateT;

    logic          ckSync1R, ckSync2R, dtSync1R, dtSync2R;
    logic          ckFiltR;
    logic [FW-1:0] filtCntR;
    logic          ckDiffS, fallS;

    stateT         stateR, stateNextS;
    logic [2:0]    bitCntR, bitCntNextS;
    logic [TW-1:0] toCntR, toCntNextS, toCntIncS;
    logic [7:0]    shiftR, shiftNextS;
    logic          doneR, doneNextS;
    logic          errNextS, timeoutS, timeoutHitS, parOkS;
    logic          extR, relR;

    // Two-flop synchronizers; idle-high reset so no false edge follows reset
    always_ff @(posedge clock) begin
        if (reset) begin
            ckSync1R <= 1'b1;
            ckSync2R <= 1'b1;
            dtSync1R <= 1'b1;
            dtSync2R <= 1'b1;
        end else begin
            ckSync1R <= ps2Ck;
            ckSync2R <= ckSync1R;
            dtSync1R <= ps2Dt;
            dtSync2R <= dtSync1R;
        end
    end

    assign ckDiffS = (ckSync2R != ckFiltR);
    // The filtered level flips on the FILTER-th consecutive differing sample;
    // a flip away from a high level is the sampling edge.
    assign fallS   = ce && ckDiffS && (filtCntR == FILT_LAST) && ckFiltR;

    // Clock-line glitch filter: counts consecutive differing ce samples
    always_ff @(posedge clock) begin
        if (reset) begin
            ckFiltR  <= 1'b1;
            filtCntR <= '0;
        end else if (ce) begin
            if (!ckDiffS) begin
                filtCntR <= '0;
            end else if (filtCntR == FILT_LAST) begin
                ckFiltR  <= ckSync2R;
                filtCntR <= '0;
            end else begin
                filtCntR <= filtCntR + FW'(1);
            end
        end
    end

    assign toCntIncS   = ce ? (toCntR + TW'(1)) : toCntR;
    assign timeoutHitS = ce && (toCntR == TO_LAST);

    // Frame receiver next-state logic; timeout takes priority over an edge
    always_comb begin
        stateNextS  = stateR;
        bitCntNextS = bitCntR;
        toCntNextS  = toCntR;
        shiftNextS  = shiftR;
        doneNextS   = 1'b0;
        errNextS    = 1'b0;
        timeoutS    = 1'b0;
        case (stateR)
            IDLE: begin
                if (fallS) begin
                    if (!dtSync2R) begin
                        stateNextS  = DATA;
                        bitCntNextS = 3'd0;
                        toCntNextS  = '0;
                    end else begin
                        errNextS = 1'b1;
                    end
                end else begin
                    stateNextS = IDLE;
                end
            end
            DATA: begin
                if (timeoutHitS) begin
                    stateNextS = IDLE;
                    errNextS   = 1'b1;
                    timeoutS   = 1'b1;
                end else begin
                    toCntNextS = toCntIncS;
                    if (fallS) begin
                        shiftNextS = {dtSync2R, shiftR[7:1]};
                        if (bitCntR == 3'd7) begin
                            stateNextS = PARITY;
                        end else begin
                            bitCntNextS = bitCntR + 3'd1;
                        end
                    end else begin
                        stateNextS = DATA;
                    end
                end
            end
            PARITY: begin
                if (timeoutHitS) begin
                    stateNextS = IDLE;
                    errNextS   = 1'b1;
                    timeoutS   = 1'b1;
                end else begin
                    toCntNextS = toCntIncS;
                    if (fallS) begin
                        stateNextS = STOP;
                    end else begin
                        stateNextS = PARITY;
                    end
                end
            end
            STOP: begin
                if (timeoutHitS) begin
                    stateNextS = IDLE;
                    errNextS   = 1'b1;
                    timeoutS   = 1'b1;
                end else begin
                    toCntNextS = toCntIncS;
                    if (fallS) begin
                        stateNextS = IDLE;
                        if (dtSync2R && parOkS) begin
                            doneNextS = 1'b1;
                        end else begin
                            errNextS = 1'b1;
                        end
                    end else begin
                        stateNextS = STOP;
                    end
                end
            end
            default: begin
                stateNextS = IDLE;
            end
        endcase
    end

    // Frame receiver state, counters, shift register and error pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            stateR  <= IDLE;
            bitCntR <= 3'd0;
            toCntR  <= '0;
            shiftR  <= 8'h00;
            doneR   <= 1'b0;
            error   <= 1'b0;
        end else begin
            stateR  <= stateNextS;
            bitCntR <= bitCntNextS;
            toCntR  <= toCntNextS;
            shiftR  <= shiftNextS;
            doneR   <= doneNextS;
            error   <= errNextS;
        end
    end

`ifdef PS2_PARITY_EN
    logic parAccR;

    // Odd-parity accumulator over the 8 data bits and the parity bit
    always_ff @(posedge clock) begin
        if (reset) begin
            parAccR <= 1'b0;
        end else if (stateR == IDLE) begin
            parAccR <= 1'b0;
        end else if (((stateR == DATA) || (stateR == PARITY)) && fallS) begin
            parAccR <= parAccR ^ dtSync2R;
        end else begin
            parAccR <= parAccR;
        end
    end

    assign parOkS = parAccR;
`else
    assign parOkS = 1'b1;
`endif

    // Prefix flags and key-event outputs, one clock after the stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            extR     <= 1'b0;
            relR     <= 1'b0;
            strobe   <= 1'b0;
            pressed  <= 1'b0;
            extended <= 1'b0;
            code     <= 8'h00;
        end else begin
            strobe <= 1'b0;
            if (timeoutS) begin
                extR <= 1'b0;
                relR <= 1'b0;
            end else if (doneR) begin
                case (shiftR)
                    8'hE0: extR <= 1'b1;
                    8'hF0: relR <= 1'b1;
                    default: begin
                        strobe   <= 1'b1;
                        code     <= shiftR;
                        pressed  <= !relR;
                        extended <= extR;
                        extR     <= 1'b0;
                        relR     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx -- directed testbench for ps2_key_rx (FILTER=4, TIMEOUT=512).
// Drives PS/2 frames bit by bit and checks the decoded key events.
module tb_ps2_key_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 512;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       ps2Ck;
    logic       ps2Dt;
    logic       strobe, pressed, extended, error;
    logic [7:0] code;

    int checkCnt = 0;
    int failCnt  = 0;
    int strobeCnt = 0;
    int errCnt    = 0;
    int bothCnt   = 0;
    int s0, e0;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .ce(ce), .ps2Ck(ps2Ck), .ps2Dt(ps2Dt),
        .strobe(strobe), .pressed(pressed), .extended(extended),
        .code(code), .error(error)
    );

    always #5 clock = ~clock;

    // ce pulses high every other clock
    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clock);
            #1 ce = ~ce;
        end
    end

    // Event monitor sampled away from the active edge
    always @(negedge clock) begin
        if (strobe) strobeCnt = strobeCnt + 1;
        if (error) errCnt = errCnt + 1;
        if (strobe && error) bothCnt = bothCnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt = checkCnt + 1;
        if (got !== exp) begin
            failCnt = failCnt + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic waitCe(input int n);
        repeat (n) begin
            do @(posedge clock); while (ce !== 1'b1);
        end
        #1;
    endtask

    task automatic sendBit(input logic b);
        ps2Dt = b;
        waitCe(3);
        ps2Ck = 1'b0;
        waitCe(6);
        ps2Ck = 1'b1;
        waitCe(3);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic parFlip, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(~(^b) ^ parFlip);
        sendBit(stopBit);
        ps2Dt = 1'b1;
        waitCe(6);
    endtask

    task automatic mark();
        s0 = strobeCnt;
        e0 = errCnt;
    endtask

    initial begin
        reset = 1'b1;
        ps2Ck = 1'b1;
        ps2Dt = 1'b1;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        waitCe(4);
        checkVal("rst_strobe", 32'(strobe), 32'd0);
        checkVal("rst_error", 32'(error), 32'd0);
        checkVal("rst_code", 32'(code), 32'h00);
        checkVal("rst_pressed", 32'(pressed), 32'd0);
        checkVal("rst_extended", 32'(extended), 32'd0);

        // Plain make code
        mark();
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("make_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("make_errors", 32'(errCnt - e0), 32'd0);
        checkVal("make_code", 32'(code), 32'h1C);
        checkVal("make_pressed", 32'(pressed), 32'd1);
        checkVal("make_ext", 32'(extended), 32'd0);

        // Break then make again
        mark();
        sendFrame(8'hF0, 1'b0, 1'b1);
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("brk_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("brk_code", 32'(code), 32'h1C);
        checkVal("brk_pressed", 32'(pressed), 32'd0);
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("remake_pressed", 32'(pressed), 32'd1);

        // Extended break: prefixes alone produce no strobe and outputs hold
        mark();
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'hF0, 1'b0, 1'b1);
        checkVal("pfx_strobes", 32'(strobeCnt - s0), 32'd0);
        checkVal("pfx_code_hold", 32'(code), 32'h1C);
        checkVal("pfx_pressed_hold", 32'(pressed), 32'd1);
        sendFrame(8'h75, 1'b0, 1'b1);
        checkVal("extbrk_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("extbrk_code", 32'(code), 32'h75);
        checkVal("extbrk_pressed", 32'(pressed), 32'd0);
        checkVal("extbrk_ext", 32'(extended), 32'd1);
        sendFrame(8'h75, 1'b0, 1'b1);
        checkVal("flagclr_pressed", 32'(pressed), 32'd1);
        checkVal("flagclr_ext", 32'(extended), 32'd0);

        // Repeated prefixes are idempotent
        mark();
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'hF0, 1'b0, 1'b1);
        sendFrame(8'hF0, 1'b0, 1'b1);
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("rep_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("rep_ext", 32'(extended), 32'd1);
        checkVal("rep_pressed", 32'(pressed), 32'd0);

        // E1 is an ordinary code
        sendFrame(8'hE1, 1'b0, 1'b1);
        checkVal("e1_code", 32'(code), 32'hE1);
        checkVal("e1_pressed", 32'(pressed), 32'd1);
        checkVal("e1_ext", 32'(extended), 32'd0);

        // Wrong parity bit
        mark();
        sendFrame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_EN
        checkVal("par_errors", 32'(errCnt - e0), 32'd1);
        checkVal("par_strobes", 32'(strobeCnt - s0), 32'd0);
        checkVal("par_code", 32'(code), 32'hE1);
`else
        checkVal("par_errors", 32'(errCnt - e0), 32'd0);
        checkVal("par_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("par_code", 32'(code), 32'h1C);
`endif

        // Bad stop bit
        mark();
        sendFrame(8'h2A, 1'b0, 1'b0);
        checkVal("stop_errors", 32'(errCnt - e0), 32'd1);
        checkVal("stop_strobes", 32'(strobeCnt - s0), 32'd0);

        // Start bit sampled high
        mark();
        sendBit(1'b1);
        waitCe(6);
        checkVal("start_errors", 32'(errCnt - e0), 32'd1);
        checkVal("start_strobes", 32'(strobeCnt - s0), 32'd0);

        // Timeout after 4 bits clears a pending E0
        sendFrame(8'hE0, 1'b0, 1'b1);
        mark();
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        ps2Dt = 1'b1;
        waitCe(TIMEOUT);
        checkVal("to_errors", 32'(errCnt - e0), 32'd1);
        checkVal("to_strobes", 32'(strobeCnt - s0), 32'd0);
        mark();
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("to_next_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("to_next_code", 32'(code), 32'h1C);
        checkVal("to_next_ext", 32'(extended), 32'd0);

        // Glitches of FILTER-1 ce samples with data low
        mark();
        ps2Dt = 1'b0;
        for (int g = 0; g < 4; g++) begin
            ps2Ck = 1'b0;
            waitCe(FILTER - 1);
            ps2Ck = 1'b1;
            waitCe(6);
        end
        ps2Dt = 1'b1;
        waitCe(6);
        checkVal("glitch_errors", 32'(errCnt - e0), 32'd0);
        checkVal("glitch_strobes", 32'(strobeCnt - s0), 32'd0);
        sendFrame(8'h5A, 1'b0, 1'b1);
        checkVal("glitch_next_code", 32'(code), 32'h5A);
        checkVal("glitch_next_strobes", 32'(strobeCnt - s0), 32'd1);

        // Reset mid-frame
        mark();
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        ps2Dt = 1'b1;
        waitCe(10);
        checkVal("midrst_errors", 32'(errCnt - e0), 32'd0);
        checkVal("midrst_strobes", 32'(strobeCnt - s0), 32'd0);
        checkVal("midrst_code", 32'(code), 32'h00);
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkVal("midrst_next_code", 32'(code), 32'h1C);
        checkVal("midrst_next_strobes", 32'(strobeCnt - s0), 32'd1);
        checkVal("midrst_next_pressed", 32'(pressed), 32'd1);

        checkVal("strobe_error_overlap", 32'(bothCnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
